// File: rtl/ext_int_arbiter_pkg.sv
// Shared types, register map and helpers for the machine external interrupt arbiter.
// Optional build macro used by this block: EXT_INT_SYNC_EN (see ext_int_gateway).
package ext_int_arbiter_pkg;

  localparam int EI_ADDR_W = 5;
  localparam int EI_PRIO_W = 3;

  typedef logic [4:0]           src_id_t;  // 0 = "none", 1..31 = source IDs
  typedef logic [EI_PRIO_W-1:0] prio_t;

  // Word addresses of the software-visible registers
  localparam logic [EI_ADDR_W-1:0] EI_ENABLE     = 5'h00;
  localparam logic [EI_ADDR_W-1:0] EI_EDGE       = 5'h01;
  localparam logic [EI_ADDR_W-1:0] EI_PENDING    = 5'h02;
  localparam logic [EI_ADDR_W-1:0] EI_THRESHOLD  = 5'h03;
  localparam logic [EI_ADDR_W-1:0] EI_CLAIM      = 5'h04;
  localparam logic [EI_ADDR_W-1:0] EI_IN_SERVICE = 5'h05;
  localparam logic [EI_ADDR_W-1:0] EI_PRIO_BASE  = 5'h08;

  // mcause code reported to the trap logic for a given winner ID
  function automatic logic [30:0] ext_int_code(input src_id_t id, input logic [30:0] base);
    return base + 31'(id);
  endfunction

  // Word address of the priority register for zero-based source index idx (ID idx+1)
  function automatic logic [EI_ADDR_W-1:0] prio_addr(input int idx);
    return EI_ADDR_W'(int'(EI_PRIO_BASE) + idx);
  endfunction

endpackage

// File: rtl/ext_int_arbiter_if.sv
// Word-addressed register port between the system bus and the interrupt arbiter.
interface ext_int_arbiter_if;
  import ext_int_arbiter_pkg::*;

  logic [EI_ADDR_W-1:0] bus_addr;
  logic                 bus_we;
  logic                 bus_re;
  logic [31:0]          bus_wdata;
  logic [31:0]          bus_rdata;

  modport master (output bus_addr, bus_we, bus_re, bus_wdata, input bus_rdata);
  modport slave  (input bus_addr, bus_we, bus_re, bus_wdata, output bus_rdata);
endinterface

// File: rtl/ext_int_gateway.sv
// Per-source interrupt gateway: optional input synchronizer, edge/level detection,
// and the PENDING / IN_SERVICE flops for one source.
// Build macro: EXT_INT_SYNC_EN adds a 2-flop synchronizer on irq_raw (+2 cycles).
module ext_int_gateway (
  input  logic clk,
  input  logic rst_sync_n,
  input  logic irq_raw,
  input  logic edge_mode,   // 1 = rising-edge triggered, 0 = level
  input  logic claim,       // this source is being claimed this cycle
  input  logic complete,    // this source is being completed this cycle
  output logic pending,
  output logic in_service
);

  logic irq_s;
  logic irq_prev;
  logic set_req;

`ifdef EXT_INT_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer for asynchronous peripheral lines
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_sync_n) sync_q <= '0;
    else             sync_q <= {sync_q[0], irq_raw};
  end

  assign irq_s = sync_q[1];
`else
  assign irq_s = irq_raw;
`endif

  // Request detection; a level request is held off while the source is in service or
  // being claimed, so a claim of a still-high line does not leave it pending behind.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves set_req unassigned (latch).
    set_req = 1'b0;
    if (edge_mode) set_req = irq_s & ~irq_prev;
    else           set_req = irq_s & ~in_service & ~claim;
  end

  // Pending/in-service flops: a new request wins over a same-cycle claim
  always_ff @(posedge clk) begin
    if (!rst_sync_n) begin
      irq_prev   <= 1'b0;
      pending    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      irq_prev   <= irq_s;
      pending    <= set_req | (pending & ~claim);
      in_service <= claim | (in_service & ~complete);
    end
  end

endmodule

// File: rtl/ext_int_arbiter.sv
// Machine external interrupt arbiter: register file, registered priority selection,
// claim/complete decode and the meip / custom_int_code outputs to the core.
// Build macro: EXT_INT_SYNC_EN (input synchronizers inside each ext_int_gateway).
module ext_int_arbiter
  import ext_int_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = 8,
  parameter int PRIO_W    = EI_PRIO_W,
  parameter int CODE_BASE = 16
) (
  input  logic               clk,
  input  logic               rst_sync_n,
  input  logic [NUM_SRC-1:0] irq_src,
  ext_int_arbiter_if.slave   bus,
  output logic               meip,
  output logic [30:0]        custom_int_code
);

  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] edge_q;
  logic [PRIO_W-1:0]  threshold_q;
  logic [PRIO_W-1:0]  prio_q [NUM_SRC];

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_service;
  logic [NUM_SRC-1:0] claim_vec;
  logic [NUM_SRC-1:0] complete_vec;
  logic [NUM_SRC-1:0] eligible;

  src_id_t           winner_q;
  src_id_t           best_id;
  logic [PRIO_W-1:0] best_prio;
  logic              claim_req;
  logic              complete_req;
  logic [31:0]       rd_val;

  // A claim only has side effects when there is a winner to hand out
  assign claim_req    = bus.bus_re && (bus.bus_addr == EI_CLAIM) && (winner_q != '0);
  assign complete_req = bus.bus_we && (bus.bus_addr == EI_CLAIM);

  // One-hot claim/complete strobes; completes for IDs not in service fall out naturally
  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      claim_vec[i-1]    = claim_req && (winner_q == src_id_t'(i));
      complete_vec[i-1] = complete_req && (bus.bus_wdata == 32'(i)) && in_service[i-1];
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
    ext_int_gateway u_gw (
      .clk        (clk),
      .rst_sync_n (rst_sync_n),
      .irq_raw    (irq_src[g]),
      .edge_mode  (edge_q[g]),
      .claim      (claim_vec[g]),
      .complete   (complete_vec[g]),
      .pending    (pending[g]),
      .in_service (in_service[g])
    );
  end

  // The source being claimed is dropped immediately so back-to-back claims never repeat it
  assign eligible = pending & enable_q & ~in_service & ~claim_vec;

  // Priority select: strictly above threshold, highest priority, ties to the lowest ID
  always_comb begin
    best_id   = '0;
    best_prio = threshold_q;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (eligible[i-1] && (prio_q[i-1] > best_prio)) begin
        best_id   = src_id_t'(i);
        best_prio = prio_q[i-1];
      end
    end
  end

  // Registered winner keeps the selection logic off the trap-cause path
  always_ff @(posedge clk) begin
    if (!rst_sync_n) winner_q <= '0;
    else             winner_q <= best_id;
  end

  assign meip            = (winner_q != '0);
  assign custom_int_code = ext_int_code(winner_q, 31'(CODE_BASE));

  // Software-writable configuration registers
  always_ff @(posedge clk) begin
    if (!rst_sync_n) begin
      enable_q    <= '0;
      edge_q      <= '0;
      threshold_q <= '0;
      // NOTE: the priority array is a handful of flops, not a RAM, so it is reset like any register.
      for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
    end else if (bus.bus_we) begin
      case (bus.bus_addr)
        EI_ENABLE:    enable_q    <= bus.bus_wdata[NUM_SRC-1:0];
        EI_EDGE:      edge_q      <= bus.bus_wdata[NUM_SRC-1:0];
        EI_THRESHOLD: threshold_q <= bus.bus_wdata[PRIO_W-1:0];
        default: begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.bus_addr == prio_addr(i)) prio_q[i] <= bus.bus_wdata[PRIO_W-1:0];
          end
        end
      endcase
    end
  end

  // Read mux over pre-edge state, so a same-cycle write is not visible to the read
  always_comb begin
    rd_val = '0;
    case (bus.bus_addr)
      EI_ENABLE:     rd_val = 32'(enable_q);
      EI_EDGE:       rd_val = 32'(edge_q);
      EI_PENDING:    rd_val = 32'(pending);
      EI_THRESHOLD:  rd_val = 32'(threshold_q);
      EI_CLAIM:      rd_val = 32'(winner_q);
      EI_IN_SERVICE: rd_val = 32'(in_service);
      default: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (bus.bus_addr == prio_addr(i)) rd_val = 32'(prio_q[i]);
        end
      end
    endcase
  end

  // Registered read data, valid the cycle after bus_re and zero otherwise
  always_ff @(posedge clk) begin
    if (!rst_sync_n)     bus.bus_rdata <= '0;
    else if (bus.bus_re) bus.bus_rdata <= rd_val;
    else                 bus.bus_rdata <= '0;
  end

endmodule

// File: tb/tb_ext_int_arbiter.sv
// Scoreboard bench for ext_int_arbiter: stimulus pushes expected read data and expected
// meip/code values into queues; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_ext_int_arbiter;
  import ext_int_arbiter_pkg::*;

  localparam int CODE_BASE = 16;
`ifdef EXT_INT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic        clk        = 1'b0;
  logic        rst_sync_n = 1'b0;
  logic [7:0]  irq_src    = '0;
  logic        meip;
  logic [30:0] custom_int_code;

  ext_int_arbiter_if intf ();

  ext_int_arbiter #(.NUM_SRC(8), .PRIO_W(3), .CODE_BASE(CODE_BASE)) dut (
    .clk             (clk),
    .rst_sync_n      (rst_sync_n),
    .irq_src         (irq_src),
    .bus             (intf),
    .meip            (meip),
    .custom_int_code (custom_int_code)
  );

  always #5 clk = ~clk;

  exp_t rd_q[$];
  exp_t sig_q[$];
  int   total   = 0;
  int   bad     = 0;
  logic rd_fl   = 1'b0;
  logic end_req = 1'b0;
  logic end_ack = 1'b0;

  // A read issued at a posedge has its data on bus_rdata after that edge
  always @(posedge clk) rd_fl <= intf.bus_re;

  // Monitor: compares read data and meip/code against the queued expectations
  always @(negedge clk) begin
    exp_t e;
    if (rd_fl) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got %h want no read", intf.bus_rdata);
      end else begin
        e = rd_q.pop_front();
        if (intf.bus_rdata !== e.val) begin
          bad++;
          $display("FAIL %s: rdata got %h want %h", e.name, intf.bus_rdata, e.val);
        end
      end
    end
    while (sig_q.size() != 0) begin
      e = sig_q.pop_front();
      total++;
      if ({meip, custom_int_code} !== e.val) begin
        bad++;
        $display("FAIL %s: meip/code got %0b/%0d want %0b/%0d",
                 e.name, meip, custom_int_code, e.val[31], e.val[30:0]);
      end
    end
    if (end_req && !end_ack) begin
      total++;
      if (rd_q.size() + sig_q.size() != 0) begin
        bad++;
        $display("FAIL leftover: got %0d unchecked want 0", rd_q.size() + sig_q.size());
      end
      end_ack = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (SYNC_LAT) tick();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    intf.bus_addr  = a;
    intf.bus_wdata = d;
    intf.bus_we    = 1'b1;
    tick();
    intf.bus_we    = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string n);
    intf.bus_addr = a;
    intf.bus_re   = 1'b1;
    rd_q.push_back('{name: n, val: e});
    tick();
    intf.bus_re   = 1'b0;
  endtask

  task automatic rdwr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] e,
                      input string n);
    intf.bus_addr  = a;
    intf.bus_wdata = d;
    intf.bus_we    = 1'b1;
    intf.bus_re    = 1'b1;
    rd_q.push_back('{name: n, val: e});
    tick();
    intf.bus_we    = 1'b0;
    intf.bus_re    = 1'b0;
  endtask

  task automatic chk_irq(input string n, input int id);
    sig_q.push_back('{name: n, val: {(id != 0), 31'(CODE_BASE + id)}});
  endtask

  task automatic do_reset();
    rst_sync_n  = 1'b0;
    irq_src     = '0;
    intf.bus_re = 1'b0;
    intf.bus_we = 1'b0;
    tick();
    tick();
    rst_sync_n  = 1'b1;
  endtask

  initial begin
    intf.bus_addr  = '0;
    intf.bus_wdata = '0;
    intf.bus_we    = 1'b0;
    intf.bus_re    = 1'b0;

    // 1: reset state, single level source, claim and complete
    do_reset();
    chk_irq("rst_meip", 0);
    rd(EI_ENABLE, 0, "rst_enable");
    rd(EI_PENDING, 0, "rst_pending");
    rd(EI_IN_SERVICE, 0, "rst_in_service");
    rd(EI_THRESHOLD, 0, "rst_threshold");
    rd(EI_CLAIM, 0, "rst_claim");
    rd(5'h0A, 0, "rst_prio3");
    wr(5'h0A, 2);
    wr(EI_ENABLE, 32'h04);
    irq_src[2] = 1'b1; settle(); tick(); irq_src[2] = 1'b0;
    chk_irq("t1_lat1", 0);
    tick();
    chk_irq("t1_meip", 3);
    rd(EI_PENDING, 32'h04, "t1_pending");
    rd(EI_CLAIM, 3, "t1_claim");
    chk_irq("t1_after_claim", 0);
    rd(EI_IN_SERVICE, 32'h04, "t1_in_service");
    wr(EI_CLAIM, 3);
    rd(EI_IN_SERVICE, 0, "t1_complete");

    // 2: equal priorities, tie to lowest ID, then exhaustion
    do_reset();
    wr(5'h09, 4);
    wr(5'h0C, 4);
    wr(EI_ENABLE, 32'h12);
    irq_src = 8'h12; settle(); tick(); irq_src = '0;
    tick();
    chk_irq("t2_win", 2);
    rd(EI_CLAIM, 2, "t2_claim_a");
    rd(EI_CLAIM, 5, "t2_claim_b");
    rd(EI_CLAIM, 0, "t2_claim_c");
    rd(EI_IN_SERVICE, 32'h12, "t2_in_service");
    rd(EI_PENDING, 0, "t2_pending");
    chk_irq("t2_idle", 0);

    // 3: threshold masks equal priority, lowering it releases the source
    do_reset();
    wr(EI_THRESHOLD, 4);
    wr(5'h08, 4);
    wr(EI_ENABLE, 32'h01);
    irq_src[0] = 1'b1; settle(); tick(); irq_src[0] = 1'b0;
    tick();
    tick();
    chk_irq("t3_masked", 0);
    rd(EI_PENDING, 32'h01, "t3_pending");
    wr(EI_THRESHOLD, 3);
    chk_irq("t3_thr_edge", 0);
    tick();
    chk_irq("t3_thr_win", 1);

    // 4: edge source re-pends while in service, fires again after complete
    do_reset();
    wr(EI_EDGE, 32'h20);
    wr(EI_ENABLE, 32'h20);
    wr(5'h0D, 1);
    irq_src[5] = 1'b1; settle(); tick();
    tick();
    chk_irq("t4_win", 6);
    rd(EI_CLAIM, 6, "t4_claim");
    chk_irq("t4_claimed", 0);
    rd(EI_PENDING, 0, "t4_pend_clr");
    irq_src[5] = 1'b0; tick();
    irq_src[5] = 1'b1; settle(); tick();
    rd(EI_PENDING, 32'h20, "t4_repend");
    chk_irq("t4_in_service", 0);
    wr(EI_CLAIM, 6);
    chk_irq("t4_cmp_edge", 0);
    tick();
    chk_irq("t4_rewin", 6);

    // 5: held level source, bogus completes, claim+complete together, register corners
    do_reset();
    wr(5'h0B, 3);
    wr(EI_ENABLE, 32'h08);
    irq_src[3] = 1'b1; settle(); tick();
    tick();
    chk_irq("t5_win", 4);
    rd(EI_CLAIM, 4, "t5_claim");
    rd(EI_PENDING, 0, "t5_pend_clr");
    rd(EI_IN_SERVICE, 32'h08, "t5_in_service");
    wr(EI_CLAIM, 0);
    wr(EI_CLAIM, 9);
    wr(EI_CLAIM, 2);
    rd(EI_IN_SERVICE, 32'h08, "t5_bad_cmp");
    rd(EI_PENDING, 0, "t5_still_held");
    chk_irq("t5_nowin", 0);
    wr(EI_CLAIM, 4);
    tick();
    rd(EI_PENDING, 32'h08, "t5_relevel");
    chk_irq("t5_rewin", 4);
    wr(5'h0E, 2);
    wr(EI_ENABLE, 32'h48);
    rd(EI_CLAIM, 4, "t5_claim2");
    irq_src[6] = 1'b1; settle(); tick(); irq_src[6] = 1'b0;
    tick();
    chk_irq("t5_win7", 7);
    rdwr(EI_CLAIM, 4, 7, "t5_claim_cmp");
    rd(EI_IN_SERVICE, 32'h40, "t5_both_apply");
    rd(EI_PENDING, 32'h08, "t5_pend4");
    chk_irq("t5_win4", 4);
    rdwr(EI_ENABLE, 32'hFF, 32'h48, "t5_rw_same");
    rd(EI_ENABLE, 32'hFF, "t5_enable_new");
    wr(EI_THRESHOLD, 32'h1F);
    rd(EI_THRESHOLD, 7, "t5_thr_mask");
    wr(5'h06, 32'hFFFF);
    rd(5'h06, 0, "t5_unmapped");
    rd(5'h0E, 2, "t5_prio7");

    // 6: reset while a source is in service and a claim is in flight
    do_reset();
    wr(5'h0C, 5);
    wr(5'h08, 1);
    wr(EI_ENABLE, 32'h11);
    irq_src = 8'h11; settle(); tick(); irq_src = '0;
    tick();
    chk_irq("t6_win", 5);
    rd(EI_CLAIM, 5, "t6_claim");
    chk_irq("t6_next", 1);
    rd(EI_IN_SERVICE, 32'h10, "t6_in_service");
    intf.bus_addr = EI_CLAIM;
    intf.bus_re   = 1'b1;
    rst_sync_n    = 1'b0;
    rd_q.push_back('{name: "t6_rst_rdata", val: 32'h0});
    tick();
    intf.bus_re   = 1'b0;
    rst_sync_n    = 1'b1;
    chk_irq("t6_rst_meip", 0);
    rd(EI_IN_SERVICE, 0, "t6_rst_in_service");
    rd(EI_PENDING, 0, "t6_rst_pending");
    rd(EI_ENABLE, 0, "t6_rst_enable");
    rd(5'h0C, 0, "t6_rst_prio5");
    rd(EI_EDGE, 0, "t6_rst_edge");

    tick();
    tick();
    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
